// File: rtl/gf_inverse_seq_if.sv
// ---------------------------------------------------------------------------
// gf_inverse_seq_if
//   Handshake bundle between a divisor source, the sequential GF(2^SIZE)
//   inverter and the downstream multiplier.
//
//   Signals:
//     in_valid / in_ready / in_b           divisor request channel
//     out_valid / out_ready                result channel
//     out_inv / out_zero                   inverse and divide-by-zero flag
//     in_a / out_a                         dividend passthrough, present only
//                                          when GF_INV_OPERAND_EN is defined
//
//   Modports:
//     master : divisor source / result consumer side
//     slave  : inverter side
// ---------------------------------------------------------------------------
interface gf_inverse_seq_if #(
    parameter int SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_inv;
    logic            out_zero;
`ifdef GF_INV_OPERAND_EN
    logic [SIZE-1:0] in_a;
    logic [SIZE-1:0] out_a;

    modport master (
        output in_valid, in_b, in_a, out_ready,
        input  in_ready, out_valid, out_inv, out_zero, out_a
    );
    modport slave (
        input  in_valid, in_b, in_a, out_ready,
        output in_ready, out_valid, out_inv, out_zero, out_a
    );
`else
    modport master (
        output in_valid, in_b, out_ready,
        input  in_ready, out_valid, out_inv, out_zero
    );
    modport slave (
        input  in_valid, in_b, out_ready,
        output in_ready, out_valid, out_inv, out_zero
    );
`endif
endinterface

// File: rtl/gf_inverse_seq.sv
// ---------------------------------------------------------------------------
// gf_inverse_seq
//   Sequential multiplicative inverter over GF(2^SIZE) modulo POLY.
//   b^-1 = b^(2^SIZE-2) = b^2 * b^4 * ... * b^(2^(SIZE-1)); one squaring and
//   one multiply per CALC cycle, SIZE-1 CALC cycles per operation.
//   b == 0 falls out of the math as 0 and is additionally flagged on out_zero.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous, active-high reset
//     bus   gf_inverse_seq_if.slave
//             in_valid/in_ready/in_b     divisor accept (in_ready only in IDLE)
//             out_valid/out_ready        result handshake (held in DONE)
//             out_inv/out_zero           inverse and divide-by-zero flag
//             in_a/out_a                 dividend carried alongside the
//                                        result (GF_INV_OPERAND_EN only)
//
//   Configuration macro: GF_INV_OPERAND_EN
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a divisor, in_ready high
//   CALC  | iterating sq <= sq^2, acc <= acc * sq^2 for SIZE-1 cycles
//   DONE  | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module gf_inverse_seq #(
    parameter int              SIZE = 8,
    parameter logic [SIZE:0]   POLY = 9'b100011011
) (
    input  logic            clk,
    input  logic            rst,
    gf_inverse_seq_if.slave bus
);
    localparam int CNT_W = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Carry-less product into a 2*SIZE word, then fold the upper bits back
    // with POLY from the top bit downwards.
    function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] x,
                                               input logic [SIZE-1:0] y);
        logic [2*SIZE-1:0] p;
        p = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (y[i]) p = p ^ ({{SIZE{1'b0}}, x} << i);
        end
        for (int i = 2*SIZE-2; i >= SIZE; i--) begin
            if (p[i]) p = p ^ ({{(SIZE-1){1'b0}}, POLY} << (i - SIZE));
        end
        return p[SIZE-1:0];
    endfunction

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [SIZE-1:0]   out_inv_q;
    logic              out_zero_q;
    logic [SIZE-1:0]   sq_q;
    logic [SIZE-1:0]   acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              zero_q;
    logic [SIZE-1:0]   sq_d;
    logic [SIZE-1:0]   acc_d;
`ifdef GF_INV_OPERAND_EN
    logic [SIZE-1:0]   a_q;
`endif

    assign sq_d  = gf_mul(sq_q, sq_q);
    assign acc_d = gf_mul(acc_q, sq_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_inv_q   <= '0;
            out_zero_q  <= 1'b0;
            sq_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
`ifdef GF_INV_OPERAND_EN
            a_q         <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sq_q       <= bus.in_b;
                        acc_q      <= {{(SIZE-1){1'b0}}, 1'b1};
                        cnt_q      <= '0;
                        zero_q     <= (bus.in_b == '0);
`ifdef GF_INV_OPERAND_EN
                        a_q        <= bus.in_a;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    sq_q  <= sq_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Last iteration: publish the freshly computed product
                    // directly so out_valid rises together with the result.
                    if (cnt_q == CNT_W'(SIZE - 2)) begin
                        out_inv_q   <= acc_d;
                        out_zero_q  <= zero_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inv   = out_inv_q;
    assign bus.out_zero  = out_zero_q;
`ifdef GF_INV_OPERAND_EN
    assign bus.out_a     = a_q;
`endif

endmodule
